// File: rtl/fetch_prefetch.sv
// Instruction fetch front end: issues sequential word reads to the RAM read
// channel, buffers returned words in a small FIFO and hands them to decode.
module fetch_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_sig_read,
    input  logic [31:0] mem_data,
    input  logic        mem_is_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [1:0] SIG_IDLE = 2'd0;
    localparam logic [1:0] SIG_WORD = 2'd3;
    localparam logic [31:0] PC_ALIGN = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   req_pc, req_pc_next;
    logic [31:0]   address_next;
    logic [1:0]    sig_read_next;
    logic          discard, discard_next;

    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          in_flight;
    logic          room;
    logic          push;
    logic          pop;

    // Reserve a slot for the fetch in flight so a returning word always fits.
    assign in_flight = (state == REQ) || (state == WAIT_DATA);
    assign room      = ({1'b0, count} + {{CW{1'b0}}, in_flight}) < DEPTH_W;

    assign instr_valid = (count != '0);
    assign instr_data  = fifo_data[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        address_next  = mem_address;
        sig_read_next = mem_sig_read;
        discard_next  = discard;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect_valid && room && mem_is_ready) begin
                    address_next  = fetch_pc;
                    sig_read_next = SIG_WORD;
                    req_pc_next   = fetch_pc;
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = REQ;
                end
            end
            REQ: begin
                sig_read_next = SIG_IDLE;
                state_next    = WAIT_DATA;
                if (redirect_valid) begin
                    discard_next = 1'b1;
                end
            end
            WAIT_DATA: begin
                // The RAM request cannot be cancelled; a stale word is simply dropped.
                if (mem_is_ready) begin
                    push         = !discard && !redirect_valid;
                    discard_next = 1'b0;
                    state_next   = IDLE;
                end else if (redirect_valid) begin
                    discard_next = 1'b1;
                end
            end
            default: begin
                sig_read_next = SIG_IDLE;
                state_next    = IDLE;
            end
        endcase
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc & PC_ALIGN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC & PC_ALIGN;
            req_pc       <= '0;
            mem_address  <= '0;
            mem_sig_read <= SIG_IDLE;
            discard      <= 1'b0;
        end else begin
            state        <= state_next;
            fetch_pc     <= fetch_pc_next;
            req_pc       <= req_pc_next;
            mem_address  <= address_next;
            mem_sig_read <= sig_read_next;
            discard      <= discard_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= req_pc;
                fifo_data[wr_ptr] <= mem_data;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: a RAM read-channel model, a sequential-PC stream
// model with an expected queue, and directed plus randomized redirect/stall stimulus.
`timescale 1ns/1ps
module tb_fetch_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_address;
    logic [1:0]  mem_sig_read;
    logic [31:0] mem_data;
    logic        mem_is_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .reset(reset),
        .mem_address(mem_address),
        .mem_sig_read(mem_sig_read),
        .mem_data(mem_data),
        .mem_is_ready(mem_is_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // RAM read channel: latches a word request, busy for 3 cycles, then returns addr^KEY.
    logic        stall_en;
    logic        ram_ready;
    logic [31:0] ram_data;
    logic [31:0] ram_addr;
    int          ram_cnt;
    assign mem_is_ready = ram_ready;
    assign mem_data     = ram_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_ready <= 1'b1;
            ram_data  <= '0;
            ram_addr  <= '0;
            ram_cnt   <= 0;
        end else if (ram_cnt != 0) begin
            ram_cnt <= ram_cnt - 1;
            if (ram_cnt == 1) begin
                ram_ready <= 1'b1;
                ram_data  <= ram_addr ^ KEY;
            end
        end else if (mem_sig_read == 2'd3) begin
            ram_addr  <= mem_address;
            ram_ready <= 1'b0;
            ram_cnt   <= 3;
        end else if (stall_en) begin
            ram_ready <= ($urandom_range(0, 3) != 0);
        end else begin
            ram_ready <= 1'b1;
        end
    end

    // Scoreboard state.
    int          tests = 0;
    int          fails = 0;
    int          req_cnt = 0;
    int          del_cnt = 0;
    logic        prev_req = 1'b0;
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] nxt_pc = RESET_PC;
    logic [31:0] last_pc = '0;
    logic [31:0] last_req_addr = '0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic top_up();
        while (exp_q.size() < 16) begin
            exp_q.push_back({nxt_pc, nxt_pc ^ KEY});
            nxt_pc = nxt_pc + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        nxt_pc = pc;
        top_up();
    endtask

    // Monitor: checks every request and every accepted instruction against the stream model.
    always @(negedge clk) begin
        logic [63:0] exp_item;
        if (reset) begin
            exp_req  = RESET_PC;
            restart_stream(RESET_PC);
            prev_req = 1'b0;
            req_cnt  = 0;
            del_cnt  = 0;
        end else begin
            if (mem_sig_read != 2'd0) begin
                check("req_size", {62'd0, mem_sig_read}, 64'd3);
                check("req_addr", {32'd0, mem_address}, {32'd0, exp_req});
                check("req_one_cycle", {63'd0, prev_req}, 64'd0);
                last_req_addr = mem_address;
                exp_req = exp_req + 32'd4;
                req_cnt++;
            end
            prev_req = (mem_sig_read != 2'd0);
            if (instr_valid && instr_ready && !redirect_valid) begin
                exp_item = exp_q.pop_front();
                check("instr", {instr_pc, instr_data}, exp_item);
                last_pc = instr_pc;
                del_cnt++;
                top_up();
            end
            if (redirect_valid) begin
                exp_req = redirect_pc & 32'hFFFF_FFFC;
                restart_stream(exp_req);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int target, input int budget, input string name);
        int n = 0;
        while (req_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, req_cnt >= target}, 64'd1);
    endtask

    task automatic wait_del(input int target, input int budget, input string name);
        int n = 0;
        while (del_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, {63'd0, del_cnt >= target}, 64'd1);
    endtask

    task automatic do_redirect(input logic [31:0] pc, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        instr_ready    = rdy;
        cyc(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int base;
        int d0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        stall_en       = 1'b0;
        cyc(3);
        check("rst_sig_read", {62'd0, mem_sig_read}, 64'd0);
        check("rst_address", {32'd0, mem_address}, 64'd0);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
        check("rst_data", {32'd0, instr_data}, 64'd0);
        check("rst_pc", {32'd0, instr_pc}, 64'd0);
        reset = 1'b0;

        // Sequential fetch from RESET_PC, then redirect while 0x108 is in WAIT_DATA.
        wait_req(3, 100, "first_reqs");
        check("pre_redirect_deliveries", 64'(del_cnt), 64'd2);
        cyc(1);
        do_redirect(32'h0000_2000, 1'b1);
        wait_del(3, 100, "post_redirect_delivery");
        check("post_redirect_pc", {32'd0, last_pc}, 64'h2000);

        // Fill with decode stalled: exactly DEPTH requests, then one per freed slot.
        do_redirect(32'h0000_3000, 1'b0);
        base = req_cnt;
        cyc(80);
        check("fill_reqs", 64'(req_cnt - base), 64'(DEPTH));
        check("fill_valid", {63'd0, instr_valid}, 64'd1);
        instr_ready = 1'b1;
        cyc(1);
        instr_ready = 1'b0;
        cyc(40);
        check("one_more_req", 64'(req_cnt - base), 64'(DEPTH + 1));

        // Three entries buffered, fetch in flight, redirect with a simultaneous pop.
        instr_ready = 1'b1;
        cyc(1);
        instr_ready = 1'b0;
        wait_req(base + DEPTH + 2, 40, "refill_req");
        cyc(1);
        do_redirect(32'h0000_2002, 1'b1);
        instr_ready = 1'b0;
        check("flush_valid", {63'd0, instr_valid}, 64'd0);
        wait_req(base + DEPTH + 3, 60, "post_flush_req");
        check("post_flush_addr", {32'd0, last_req_addr}, 64'h2000);

        // Address wrap past 0xFFFF_FFFC.
        d0 = del_cnt;
        do_redirect(32'hFFFF_FFF4, 1'b1);
        wait_del(d0 + 5, 200, "wrap_deliveries");
        check("wrap_last_pc", {32'd0, last_pc}, 64'h4);

        // Randomized decode backpressure, foreign RAM traffic and redirects.
        stall_en = 1'b1;
        d0 = del_cnt;
        for (int i = 0; i < 1000; i++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                end
            end else begin
                redirect_valid = 1'b0;
            end
            cyc(1);
        end
        redirect_valid = 1'b0;
        stall_en = 1'b0;
        check("random_progress", {63'd0, (del_cnt - d0) >= 20}, 64'd1);

        // Reset while a fetch is in WAIT_DATA and the FIFO holds a word.
        do_redirect(32'h0000_4000, 1'b0);
        cyc(4);
        base = req_cnt;
        wait_req(base + 2, 80, "pre_reset_reqs");
        check("pre_reset_valid", {63'd0, instr_valid}, 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_sig_read", {62'd0, mem_sig_read}, 64'd0);
        check("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
        check("mid_rst_pc", {32'd0, instr_pc}, 64'd0);
        cyc(2);
        reset = 1'b0;
        instr_ready = 1'b1;
        wait_req(1, 40, "post_reset_req");
        check("post_reset_addr", {32'd0, last_req_addr}, {32'd0, RESET_PC});
        wait_del(1, 40, "post_reset_delivery");
        check("post_reset_pc", {32'd0, last_pc}, {32'd0, RESET_PC});
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
